out_collect: RTL and testbench

Downstream frame collector for the floating-point processor top level. It samples the processor's integer output bus whenever one of the one-hot output strobes fires. It assembles one value per output channel into a frame and queues complete frames in a show-ahead FIFO. The frames drain to the host side over a valid/ready stream. It sits directly after the float-to-int converter and output address decoder.

---
 rtl/out_collect.sv | 166 ++++++++++++++++
 tb/tb_out_collect.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_collect.sv
// Frame collector: gathers one sample per output channel from one-hot strobes and queues whole frames in a show-ahead FIFO.
// Latency: 1 cycle from the strobe that completes a frame to frame_valid/frame_data (FIFO empty).
// Backpressure: frame_valid/frame_ready; a full FIFO drops the completed frame and latches overflow.
// Optional: OUT_COLLECT_TIMESTAMP_EN adds a 16-bit cycle counter and a per-frame frame_ts output.
module out_collect #(
    parameter int NUIOOU = 4,
    parameter int NBITS  = 28,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [NBITS-1:0]  io_out,
    input  logic [NUIOOU-1:0]        out_en,
    input  logic                     clr_err,
    output logic [NUIOOU*NBITS-1:0]  frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [$clog2(DEPTH):0]   fill_count,
    output logic                     overflow,
    output logic                     proto_err
`ifdef OUT_COLLECT_TIMESTAMP_EN
    ,
    output logic [15:0]              frame_ts
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = NUIOOU * NBITS;

    logic [NUIOOU-1:0] mask_q;
    logic [NBITS-1:0]  slot_q   [NUIOOU];
    logic [DW-1:0]     data_mem [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    logic              valid_q;

    logic              strobe_one;
    logic              strobe_multi;
    logic              dup_hit;
    logic              frame_done;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DW-1:0]     frame_asm;

    // Classify the strobe and build the candidate frame with the incoming sample already in its slot.
    always_comb begin
        frame_asm    = '0;
        strobe_one   = $onehot(out_en);
        strobe_multi = (out_en != '0) && !strobe_one;
        dup_hit      = strobe_one && ((mask_q & out_en) != '0);
        frame_done   = strobe_one && !dup_hit && ((mask_q | out_en) == '1);
        for (int k = 0; k < NUIOOU; k++) begin
            frame_asm[k*NBITS +: NBITS] = out_en[k] ? io_out : slot_q[k];
        end
    end

    // FIFO handshake: a full FIFO still takes a frame when the head leaves on the same edge.
    always_comb begin
        pop     = valid_q && frame_ready;
        push    = frame_done && ((count_q != CW'(DEPTH)) || pop);
        drop    = frame_done && !push;
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // Staging slots and captured-channel mask; the completing strobe clears the mask.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mask_q <= '0;
            for (int k = 0; k < NUIOOU; k++) begin
                slot_q[k] <= '0;
            end
        end else if (strobe_one) begin
            for (int k = 0; k < NUIOOU; k++) begin
                if (out_en[k]) begin
                    slot_q[k] <= io_out;
                end
            end
            mask_q <= frame_done ? '0 : (mask_q | out_en);
        end
    end

    // Frame storage, written only when a push is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int d = 0; d < DEPTH; d++) begin
                data_mem[d] <= '0;
            end
        end else if (push) begin
            data_mem[wr_ptr_q] <= frame_asm;
        end
    end

    // Pointers, occupancy and the registered valid flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            valid_q <= (count_d != '0);
        end
    end

    // Sticky error flags; an error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (strobe_multi || dup_hit) begin
                proto_err <= 1'b1;
            end else if (clr_err) begin
                proto_err <= 1'b0;
            end
        end
    end

`ifdef OUT_COLLECT_TIMESTAMP_EN
    logic [15:0] ts_q;
    logic [15:0] ts_mem [DEPTH];

    // Free-running cycle counter; its value at the completing edge travels with the frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts_q <= '0;
            for (int d = 0; d < DEPTH; d++) begin
                ts_mem[d] <= '0;
            end
        end else begin
            ts_q <= ts_q + 16'd1;
            if (push) begin
                ts_mem[wr_ptr_q] <= ts_q;
            end
        end
    end

    assign frame_ts = ts_mem[rd_ptr_q];
`endif

    assign frame_data  = data_mem[rd_ptr_q];
    assign frame_valid = valid_q;
    assign fill_count  = count_q;

endmodule

// File: tb/tb_out_collect.sv
module tb_out_collect;
    localparam int N  = 4;
    localparam int NB = 28;
    localparam int D  = 8;
    localparam int DW = N * NB;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic signed [NB-1:0]  io_out = '0;
    logic [N-1:0]          out_en = '0;
    logic                  clr_err = 1'b0;
    logic                  frame_ready = 1'b0;
    logic [DW-1:0]         frame_data;
    logic                  frame_valid;
    logic [$clog2(D):0]    fill_count;
    logic                  overflow;
    logic                  proto_err;
`ifdef OUT_COLLECT_TIMESTAMP_EN
    logic [15:0]           frame_ts;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    out_collect #(.NUIOOU(N), .NBITS(NB), .DEPTH(D)) dut (
        .clk        (clk),
        .rst        (rst),
        .io_out     (io_out),
        .out_en     (out_en),
        .clr_err    (clr_err),
        .frame_data (frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .fill_count (fill_count),
        .overflow   (overflow),
        .proto_err  (proto_err)
`ifdef OUT_COLLECT_TIMESTAMP_EN
        ,
        .frame_ts   (frame_ts)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: which channels are held, their values, the expected frame queue.
    bit            have [N];
    logic [NB-1:0] val  [N];
    int            model_cnt = 0;
    bit            m_ovf = 1'b0;
    bit            m_proto = 1'b0;
    logic [15:0]   m_cyc = '0;
    logic [DW-1:0] exp_q [$];
    logic [15:0]   ts_exp [$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) have[i] = 1'b0;
        model_cnt = 0;
        m_ovf     = 1'b0;
        m_proto   = 1'b0;
        m_cyc     = '0;
        exp_q.delete();
        ts_exp.delete();
    endtask

    task automatic model_step();
        int ones;
        int k;
        bit done;
        bit err;
        bit ovf_evt;
        bit mpop;
        logic [DW-1:0] f;
        ones    = $countones(out_en);
        k       = 0;
        done    = 1'b0;
        err     = 1'b0;
        ovf_evt = 1'b0;
        f       = '0;
        mpop    = (model_cnt > 0) && frame_ready;
        if (ones > 1) begin
            err = 1'b1;
        end else if (ones == 1) begin
            for (int i = 0; i < N; i++) if (out_en[i]) k = i;
            if (have[k]) err = 1'b1;
            have[k] = 1'b1;
            val[k]  = io_out;
            done    = 1'b1;
            for (int i = 0; i < N; i++) if (!have[i]) done = 1'b0;
        end
        if (done) begin
            for (int i = 0; i < N; i++) begin
                f[i*NB +: NB] = val[i];
                have[i] = 1'b0;
            end
            if (model_cnt < D || mpop) begin
                exp_q.push_back(f);
                ts_exp.push_back(m_cyc);
                model_cnt++;
            end else begin
                ovf_evt = 1'b1;
            end
        end
        if (mpop) model_cnt--;
        if (clr_err) begin
            m_ovf   = 1'b0;
            m_proto = 1'b0;
        end
        if (ovf_evt) m_ovf = 1'b1;
        if (err) m_proto = 1'b1;
        m_cyc = m_cyc + 16'd1;
    endtask

    // Model advances on the same edges as the design; asynchronous reset clears it at once.
    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) model_reset();
            else model_step();
        end
    end

    // Monitor: compare status every cycle and the head frame whenever the design offers one.
    initial begin
        forever begin
            @(negedge clk);
            chk("fill_count", fill_count, model_cnt);
            chk("frame_valid", frame_valid, model_cnt != 0);
            chk("overflow", overflow, m_ovf);
            chk("proto_err", proto_err, m_proto);
            if (frame_valid) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL head_frame: frame offered %0h but none expected at %0t", frame_data, $time);
                end else begin
                    chk("head_frame", frame_data, exp_q[0]);
`ifdef OUT_COLLECT_TIMESTAMP_EN
                    chk("head_ts", frame_ts, ts_exp[0]);
`endif
                    if (frame_ready) begin
                        void'(exp_q.pop_front());
                        void'(ts_exp.pop_front());
                    end
                end
            end
        end
    end

    task automatic step(input logic [N-1:0] en, input logic [NB-1:0] d);
        out_en = en;
        io_out = d;
        @(posedge clk);
        #1;
        out_en = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input bit shuffle);
        int ord [N];
        int j;
        int t;
        for (int i = 0; i < N; i++) ord[i] = i;
        if (shuffle) begin
            for (int i = N - 1; i > 0; i--) begin
                j = $urandom_range(i, 0);
                t = ord[i];
                ord[i] = ord[j];
                ord[j] = t;
            end
        end
        for (int i = 0; i < N; i++) step(N'(1) << ord[i], NB'($urandom));
    endtask

    initial begin
        #5_000_000;
        n_chk++;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        logic [DW-1:0] e;
        logic [NB-1:0] a, b1, b2, c, dd;
        logic [N-1:0]  en;
        int            r;
        int            budget;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", frame_valid, 0);
        chk("rst_count", fill_count, 0);
        chk("rst_data", frame_data, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_proto", proto_err, 0);
        rst = 1'b1;

        // Frame in channel order, held at the head
        frame_ready = 1'b0;
        step(4'b0001, NB'(5));
        step(4'b0010, NB'(-7));
        step(4'b0100, NB'(100));
        step(4'b1000, NB'(-1));
        e = {NB'(-1), NB'(100), NB'(-7), NB'(5)};
        chk("t1_valid", frame_valid, 1);
        chk("t1_count", fill_count, 1);
        chk("t1_data", frame_data, e);
        idle(2);
        chk("t1_hold", frame_data, e);

        // Out-of-order strobes plus a second frame, consumer always ready
        frame_ready = 1'b1;
        idle(1);
        step(4'b0100, NB'($urandom));
        step(4'b0001, NB'($urandom));
        step(4'b1000, NB'($urandom));
        step(4'b0010, NB'($urandom));
        send_frame(1'b1);
        idle(3);
        chk("t2_drained", fill_count, 0);

        // Fill to capacity, then one more frame is dropped
        frame_ready = 1'b0;
        repeat (D) send_frame(1'b1);
        send_frame(1'b1);
        chk("t3_ovf", overflow, 1);
        chk("t3_full", fill_count, D);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t3_ovf_clr", overflow, 0);
        // Completing edge coincides with a pop: accepted, occupancy unchanged
        step(4'b0001, NB'($urandom));
        step(4'b0010, NB'($urandom));
        step(4'b0100, NB'($urandom));
        frame_ready = 1'b1;
        step(4'b1000, NB'($urandom));
        frame_ready = 1'b0;
        chk("t3_no_ovf", overflow, 0);
        chk("t3_still_full", fill_count, D);
        frame_ready = 1'b1;
        idle(D + 2);
        chk("t3_drained", fill_count, 0);

        // Multi-hot strobe and duplicate channel
        frame_ready = 1'b0;
        a  = NB'($urandom);
        b1 = NB'($urandom);
        b2 = NB'($urandom);
        c  = NB'($urandom);
        dd = NB'($urandom);
        step(4'b0101, NB'(123));
        chk("t4_proto_multi", proto_err, 1);
        step(4'b0010, b1);
        step(4'b1000, dd);
        step(4'b0010, b2);
        chk("t4_no_frame", fill_count, 0);
        step(4'b0001, a);
        step(4'b0100, c);
        chk("t4_count", fill_count, 1);
        chk("t4_data", frame_data, {dd, c, b2, a});
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        chk("t4_proto_clr", proto_err, 0);
        clr_err = 1'b1;
        step(4'b0011, NB'($urandom));
        clr_err = 1'b0;
        chk("t4_err_wins", proto_err, 1);
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
        frame_ready = 1'b1;
        idle(3);

        // Reset with a partial frame and queued frames
        frame_ready = 1'b0;
        repeat (3) send_frame(1'b1);
        step(4'b0001, NB'($urandom));
        step(4'b0010, NB'($urandom));
        #2;
        rst = 1'b0;
        #1;
        chk("t5_valid", frame_valid, 0);
        chk("t5_count", fill_count, 0);
        chk("t5_data", frame_data, 0);
        chk("t5_ovf", overflow, 0);
        chk("t5_proto", proto_err, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        send_frame(1'b0);
        chk("t5_one_frame", fill_count, 1);
        frame_ready = 1'b1;
        idle(3);

        // Randomized traffic: first half mostly stalled to provoke drops
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom_range(99, 0);
            if (r < 75) en = N'(1) << $urandom_range(N - 1, 0);
            else if (r < 82) en = N'($urandom) | N'(3);
            else en = '0;
            if (cyc < 300) frame_ready = ($urandom_range(3, 0) == 0);
            else frame_ready = ($urandom_range(3, 0) != 0);
            clr_err = ($urandom_range(19, 0) == 0);
            step(en, NB'($urandom));
        end
        clr_err = 1'b0;

`ifdef OUT_COLLECT_TIMESTAMP_EN
        // Timestamp at cycle 20 after reset, then across the counter wrap
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        frame_ready = 1'b0;
        idle(17);
        send_frame(1'b0);
        chk("ts_20", frame_ts, 20);
        frame_ready = 1'b1;
        idle(1);
        frame_ready = 1'b0;
        budget = 0;
        while (m_cyc != 16'd2 && budget < 70000) begin
            idle(1);
            budget++;
        end
        send_frame(1'b0);
        chk("ts_wrap", frame_ts, 5);
`endif

        // Drain and confirm every expected frame was delivered
        frame_ready = 1'b1;
        budget = 0;
        while (model_cnt != 0 && budget < 100) begin
            idle(1);
            budget++;
        end
        idle(2);
        chk("end_sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
